mul_iterative: RTL and testbench
================================

MUL_ITERATIVE -- requirements
Module: mul_iterative

Interface
REQ-001 The module SHALL have no parameters; operand and result widths are fixed at 32 bits.
REQ-002 One clock; reset is synchronous and active-high. The ports SHALL be named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands and op presented.
REQ-006 in_ready  output  1  block can accept operands; equals (state==IDLE).
REQ-007 op  input  2  operation select: 00 MUL (low 32), 01 MULH (signed x signed, high), 10 MULHSU (signed a x unsigned b, high), 11 MULHU (unsigned x unsigned, high).
REQ-008 a  input  32  multiplicand (rs1).
REQ-009 b  input  32  multiplier (rs2).
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  32  selected half of the 64-bit product.

Function
REQ-013 The FSM SHALL have four states: IDLE, BUSY, FIXUP and DONE.
REQ-014 IDLE: when in_valid&in_ready at an edge, the block SHALL register op, the magnitudes |a| and |b| (sign-interpreted per op), and neg = sign(a)^sign(b) (per op); it SHALL clear the 64-bit accumulator and the 5-bit counter, then go to BUSY.
REQ-015 BUSY: each edge SHALL process one multiplier bit, LSB first. If the bit is 1, the multiplicand SHALL be added to the upper 32 accumulator bits with carry-out kept (33-bit sum). The {carry, acc} SHALL then shift right by 1, and the multiplier SHALL shift right by 1.
REQ-016 BUSY SHALL last exactly 32 edges; when counter==31 the next state SHALL be FIXUP.
REQ-017 FIXUP: if neg, the 64-bit product SHALL be replaced by its two's complement; otherwise it is unchanged. The op-selected half SHALL be latched into result, and the next state SHALL be DONE.
REQ-018 DONE: out_valid SHALL be 1, and result and out_valid SHALL be held stable until out_ready=1. On that edge the block SHALL return to IDLE.
REQ-019 Latency: out_valid SHALL rise exactly 33 edges after the accepting edge (32 BUSY + 1 FIXUP).
REQ-020 in_ready SHALL be 0 in BUSY, FIXUP and DONE. Acceptance and result handoff SHALL never coincide; a new operation needs at least one IDLE cycle.
REQ-021 Changes on a, b, op or in_valid while not in IDLE SHALL have no effect.
REQ-022 out_valid SHALL be 0 in every state except DONE. result is don't-care when out_valid=0 but SHALL hold its last value.
REQ-023 Signed magnitude: 0x80000000 SHALL be treated as magnitude 2^31 (unsigned 32-bit), with no overflow.
REQ-024 A zero product with neg=1 SHALL yield 0, because the two's complement of 0 is 0.
REQ-025 All 32-bit additions (accumulate, operand negation, product negation halves) SHALL use instances of the team cla adder.
REQ-026 The carry from the low to the high half in 64-bit negation SHALL be derived as (low==0).
REQ-027 Carry-out of the accumulate add SHALL be formed as the majority of the MSB operands and the MSB carry-in, or by an equivalent method; it SHALL NOT be dropped.

Reset
REQ-028 On rst=1 at an edge, the next state SHALL be IDLE; out_valid SHALL be 0, in_ready SHALL be 1, and result, accumulator, counter and neg SHALL be 0.
REQ-029 rst SHALL take priority over any handshake in the same cycle. Reset mid-BUSY or in DONE SHALL abandon the operation with no output.
REQ-030 in_valid asserted during the reset cycle SHALL NOT be accepted.

Verification
REQ-031 op=11, a=b=0xFFFFFFFF -> result 0xFFFFFFFE after 33 edges; op=00 with the same operands -> 0x00000001.
REQ-032 op=01, a=b=0x80000000 -> 0x40000000; op=00, a=7, b=0xFFFFFFFD -> 0xFFFFFFEB; op=01 with the same operands -> 0xFFFFFFFF.
REQ-033 op=10, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; op=01, a=0, b=0xFFFFFFFB -> 0x00000000.
REQ-034 Backpressure: out_ready=0 for 10 cycles after out_valid -> result and out_valid stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge, with in_ready=1.
REQ-035 Reset on the 10th BUSY cycle -> the next cycle has in_ready=1 and out_valid=0; a following op=00, a=3, b=5 -> 0x0000000F with the normal 33-edge latency.
REQ-036 Operand churn: a and b randomized every cycle while BUSY -> result equals the product of the values captured at acceptance.

Source files
------------

// File: rtl/mul_iterative.sv
// Iterative 32x32 shift-add multiplier covering the MUL/MULH/MULHSU/MULHU ops.
// Operands are reduced to magnitudes, multiplied unsigned over 32 cycles, then sign-fixed.

module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g, p;
    logic [32:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    // 4-bit lookahead groups; group carries chain between groups
    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        localparam int B = 4 * gi;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];
endmodule

module mul_iterative (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] mcand, mplier;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic        neg;

    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs, a_inv, b_inv;
    logic [31:0] add_sum, lo_neg, hi_neg;
    logic        add_cout, lo_unused, hi_unused, a_unused, b_unused;
    logic [63:0] prod_fix;

    // MULH treats both operands as signed, MULHSU only a
    assign a_neg = a[31] & (op == 2'b01 || op == 2'b10);
    assign b_neg = b[31] & (op == 2'b01);

    cla32 u_neg_a (.a(~a), .b(32'd0), .cin(1'b1), .sum(a_inv), .cout(a_unused));
    cla32 u_neg_b (.a(~b), .b(32'd0), .cin(1'b1), .sum(b_inv), .cout(b_unused));
    assign a_abs = a_neg ? a_inv : a;
    assign b_abs = b_neg ? b_inv : b;

    cla32 u_acc (.a(acc[63:32]), .b(mplier[0] ? mcand : 32'd0), .cin(1'b0),
                 .sum(add_sum), .cout(add_cout));

    // two's complement of the 64-bit product; low half carries into high only when all-zero
    cla32 u_neg_lo (.a(~acc[31:0]), .b(32'd0), .cin(1'b1), .sum(lo_neg), .cout(lo_unused));
    cla32 u_neg_hi (.a(~acc[63:32]), .b(32'd0), .cin(acc[31:0] == 32'd0),
                    .sum(hi_neg), .cout(hi_unused));
    assign prod_fix = neg ? {hi_neg, lo_neg} : acc;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= 2'b00;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 64'd0;
            cnt    <= 5'd0;
            neg    <= 1'b0;
            result <= 32'd0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q   <= op;
                    mcand  <= a_abs;
                    mplier <= b_abs;
                    neg    <= a_neg ^ b_neg;
                    acc    <= 64'd0;
                    cnt    <= 5'd0;
                    state  <= BUSY;
                end
                BUSY: begin
                    acc    <= {add_cout, add_sum, acc[31:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIXUP;
                end
                FIXUP: begin
                    result <= (op_q == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
                    state  <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_iterative.sv
// Directed and randomized checks of mul_iterative against a 64-bit arithmetic reference.

module tb_mul_iterative;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int compared   = 0;
    int mismatched = 0;

    mul_iterative dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [63:0] sx, sy, p;
        sx = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'd0, x};
        sy = (o == 2'b01) ? {{32{y[31]}}, y} : {32'd0, y};
        p  = sx * sy;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, churn inputs while busy, check latency/result, hold DONE for 'hold' cycles.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int hold);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 40) begin
            a = $urandom; b = $urandom; op = 2'($urandom); in_valid = 1'($urandom);
            @(posedge clk); @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_result"}, result, exp);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_hold_result"}, result, held);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        do_op("mulhu_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        do_op("mul_ff",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
        do_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        do_op("mul_7m3",  2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        do_op("mulh_7m3", 2'b01, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        do_op("mulhsu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op("mulh_zero", 2'b01, 32'd0, 32'hFFFFFFFB, 32'h00000000, 0);
        do_op("mulhsu_min", 2'b10, 32'h80000000, 32'hFFFFFFFF,
              ref_mul(2'b10, 32'h80000000, 32'hFFFFFFFF), 0);
        do_op("backpressure", 2'b00, 32'd1234, 32'd5678, 32'd7006652, 10);

        // reset on the 10th BUSY cycle, with in_valid asserted during reset
        @(negedge clk);
        in_valid = 1'b1; op = 2'b11; a = 32'hDEADBEEF; b = 32'h12345678;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_busy_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy_result", result, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst_no_accept", {31'd0, in_ready}, 32'd1);
        do_op("after_rst", 2'b00, 32'd3, 32'd5, 32'h0000000F, 0);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) ra = 32'h80000000;
            if (i % 5 == 1) rb = 32'd0;
            do_op($sformatf("rand%0d", i), ro, ra, rb, ref_mul(ro, ra, rb), i % 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
